// File: rtl/ti_roic_cfg_sequencer.sv
// Arbitrated register-write sequencer for the TI ROIC configuration port.
// Runs init-table bursts and single host writes with fixed set-up, strobe and gap timing.
module ti_roic_cfg_sequencer #(
   parameter int NUM_INIT     = 16,
   parameter int SPI_HOLD_CYC = 64,
   parameter int SPI_GAP_CYC  = 8
) (
   input  logic                        clk_5mhz,
   input  logic                        deser_reset_n,
   input  logic                        init_start,
   output logic [$clog2(NUM_INIT)-1:0] init_rd_idx,
   input  logic [23:0]                 init_rd_entry,
   input  logic                        host_req,
   input  logic [7:0]                  host_addr,
   input  logic [15:0]                 host_data,
   output logic                        host_ack,
   output logic [15:0]                 ti_roic_reg_addr,
   output logic [15:0]                 ti_roic_reg_data,
   output logic                        busy,
   output logic                        init_done,
   output logic [$clog2(NUM_INIT):0]   init_cnt
);

   localparam int IDX_W   = $clog2(NUM_INIT);
   localparam int TMR_MAX = (SPI_HOLD_CYC > SPI_GAP_CYC) ? SPI_HOLD_CYC : SPI_GAP_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);

   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_INIT - 1);
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(SPI_HOLD_CYC - 1);
   localparam logic [TMR_W-1:0] GAP_LOAD  = TMR_W'(SPI_GAP_CYC - 1);

   typedef enum logic [1:0] {IDLE, LOAD, STROBE, GAP} state_t;

   state_t            state_reg;
   logic [TMR_W-1:0]  tmr_reg;
   logic              is_init_reg;
   logic              last_reg;
   logic              init_pend_reg;
   logic              entry_is_end;

   assign entry_is_end = (init_rd_entry[23:16] == 8'hFF);

   always_ff @(posedge clk_5mhz or negedge deser_reset_n) begin
      if (!deser_reset_n) begin
         state_reg        <= IDLE;
         tmr_reg          <= '0;
         is_init_reg      <= 1'b0;
         last_reg         <= 1'b0;
         init_pend_reg    <= 1'b0;
         init_rd_idx      <= '0;
         host_ack         <= 1'b0;
         ti_roic_reg_addr <= 16'h0000;
         ti_roic_reg_data <= 16'h0000;
         busy             <= 1'b0;
         init_done        <= 1'b0;
         init_cnt         <= '0;
      end else begin
         host_ack <= 1'b0;

         // A re-init request during a host write is remembered; during a burst it is dropped.
         if (init_start && state_reg != IDLE && !is_init_reg)
            init_pend_reg <= 1'b1;

         case (state_reg)
            IDLE: begin
               // init_rd_idx is parked at 0 in IDLE so entry 0 is already on init_rd_entry.
               if (init_start || init_pend_reg) begin
                  init_pend_reg <= 1'b0;
                  init_cnt      <= '0;
                  is_init_reg   <= 1'b1;
                  if (entry_is_end) begin
                     init_done <= 1'b1;
                  end else begin
                     init_done        <= 1'b0;
                     ti_roic_reg_addr <= {8'h00, init_rd_entry[23:16]};
                     ti_roic_reg_data <= init_rd_entry[15:0];
                     state_reg        <= LOAD;
                     busy             <= 1'b1;
                  end
               end else if (host_req) begin
                  is_init_reg      <= 1'b0;
                  ti_roic_reg_addr <= {8'h00, host_addr};
                  ti_roic_reg_data <= host_data;
                  host_ack         <= 1'b1;
                  state_reg        <= LOAD;
                  busy             <= 1'b1;
               end
            end

            LOAD: begin
               ti_roic_reg_addr[15] <= 1'b1;
               tmr_reg              <= HOLD_LOAD;
               state_reg            <= STROBE;
            end

            STROBE: begin
               if (tmr_reg == '0) begin
                  ti_roic_reg_addr[15] <= 1'b0;
                  tmr_reg              <= GAP_LOAD;
                  state_reg            <= GAP;
                  // Step the table index now so the next entry is settled by the end of GAP.
                  if (is_init_reg) begin
                     if (init_rd_idx == LAST_IDX) begin
                        last_reg <= 1'b1;
                     end else begin
                        last_reg    <= 1'b0;
                        init_rd_idx <= init_rd_idx + 1'b1;
                     end
                  end
               end else begin
                  tmr_reg <= tmr_reg - 1'b1;
               end
            end

            GAP: begin
               if (tmr_reg == '0) begin
                  if (is_init_reg) begin
                     init_cnt <= init_cnt + 1'b1;
                     if (last_reg || entry_is_end) begin
                        init_done   <= 1'b1;
                        init_rd_idx <= '0;
                        last_reg    <= 1'b0;
                        state_reg   <= IDLE;
                        busy        <= 1'b0;
                     end else begin
                        ti_roic_reg_addr <= {8'h00, init_rd_entry[23:16]};
                        ti_roic_reg_data <= init_rd_entry[15:0];
                        state_reg        <= LOAD;
                     end
                  end else begin
                     state_reg <= IDLE;
                     busy      <= 1'b0;
                  end
               end else begin
                  tmr_reg <= tmr_reg - 1'b1;
               end
            end

            default: begin
               state_reg <= IDLE;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_ti_roic_cfg_sequencer.sv
// Directed bench for ti_roic_cfg_sequencer: host-write vector table plus
// hand-written burst, end-marker, reset, arbitration and pending-init sequences.
module tb_ti_roic_cfg_sequencer;

   localparam int NUM_INIT = 16;
   localparam int HOLD     = 64;
   localparam int GAPC     = 8;
   localparam int WR_CYC   = 1 + HOLD + GAPC;

   logic        clk_5mhz;
   logic        deser_reset_n;
   logic        init_start;
   logic [3:0]  init_rd_idx;
   logic [23:0] init_rd_entry;
   logic        host_req;
   logic [7:0]  host_addr;
   logic [15:0] host_data;
   logic        host_ack;
   logic [15:0] ti_roic_reg_addr;
   logic [15:0] ti_roic_reg_data;
   logic        busy;
   logic        init_done;
   logic [4:0]  init_cnt;

   logic [23:0] init_tab [NUM_INIT];
   assign init_rd_entry = init_tab[init_rd_idx];

   ti_roic_cfg_sequencer #(
      .NUM_INIT(NUM_INIT), .SPI_HOLD_CYC(HOLD), .SPI_GAP_CYC(GAPC)
   ) dut (
      .clk_5mhz(clk_5mhz), .deser_reset_n(deser_reset_n), .init_start(init_start),
      .init_rd_idx(init_rd_idx), .init_rd_entry(init_rd_entry),
      .host_req(host_req), .host_addr(host_addr), .host_data(host_data), .host_ack(host_ack),
      .ti_roic_reg_addr(ti_roic_reg_addr), .ti_roic_reg_data(ti_roic_reg_data),
      .busy(busy), .init_done(init_done), .init_cnt(init_cnt)
   );

   initial clk_5mhz = 1'b0;
   always #5 clk_5mhz = ~clk_5mhz;

   int checks = 0;
   int errors = 0;

   // Strobe monitor: records {addr, data} and high time of every completed DUT_EN pulse.
   logic [23:0] mon_q [$];
   int          mon_len [$];
   int          gap_viol = 0;
   logic        in_s = 1'b0;
   logic        have_fall = 1'b0;
   logic        stable = 1'b1;
   logic [23:0] s_word = '0;
   int          s_len = 0;
   int          low_len = 0;

   always @(negedge clk_5mhz) begin
      if (!deser_reset_n) begin
         in_s = 1'b0; have_fall = 1'b0; low_len = 0;
      end else if (ti_roic_reg_addr[15]) begin
         if (!in_s) begin
            in_s = 1'b1; s_len = 0; stable = 1'b1;
            s_word = {ti_roic_reg_addr[7:0], ti_roic_reg_data};
            if (have_fall && low_len < GAPC + 1) gap_viol++;
         end
         s_len++;
         if ({ti_roic_reg_addr[7:0], ti_roic_reg_data} != s_word || ti_roic_reg_addr[14:8] != 7'd0)
            stable = 1'b0;
      end else begin
         if (in_s) begin
            in_s = 1'b0;
            mon_q.push_back(s_word);
            mon_len.push_back(stable ? s_len : -1);
            have_fall = 1'b1; low_len = 0;
         end
         low_len++;
      end
   end

   task automatic tick();
      @(negedge clk_5mhz);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end else begin
         $display("ok   %s = %0h", name, act);
      end
   endtask

   // Compares n recorded strobes starting at base against the init table, in order.
   task automatic chk_burst(input string name, input int base, input int n);
      int bad;
      bad = 0;
      for (int k = 0; k < n; k++) begin
         if (base + k >= mon_q.size()) bad++;
         else if (mon_q[base + k] != init_tab[k] || mon_len[base + k] != HOLD) bad++;
      end
      chk(name, bad, 0);
   endtask

   typedef struct {
      logic [7:0]  addr;
      logic [15:0] data;
      logic [15:0] exp_load;
      logic [15:0] exp_strobe;
   } vec_t;
   vec_t vecs [4];

   task automatic host_write_vec(input vec_t v);
      int ok;
      host_addr = v.addr; host_data = v.data; host_req = 1'b1;
      tick();
      chk("host_ack", host_ack, 1);
      chk("load_addr", ti_roic_reg_addr, v.exp_load);
      chk("load_data", ti_roic_reg_data, v.data);
      host_req = 1'b0;
      ok = 0;
      repeat (HOLD) begin
         tick();
         if (ti_roic_reg_addr === v.exp_strobe && ti_roic_reg_data === v.data && busy && !host_ack) ok++;
      end
      chk("strobe_cycles", ok, HOLD);
      ok = 0;
      repeat (GAPC) begin
         tick();
         if (ti_roic_reg_addr === v.exp_load && ti_roic_reg_data === v.data && busy) ok++;
      end
      chk("gap_cycles", ok, GAPC);
      tick();
      chk("busy_end", busy, 0);
      chk("held_addr", ti_roic_reg_addr, v.exp_load);
   endtask

   initial begin
      int base, cnt, first_low, rehigh, burst_end, late_busy, acks, ack_at;
      logic [15:0] rehigh_addr;
      logic        rehigh_done;

      vecs[0] = '{8'h12, 16'hA5C3, 16'h0012, 16'h8012};
      vecs[1] = '{8'h00, 16'h0000, 16'h0000, 16'h8000};
      vecs[2] = '{8'hFF, 16'hFFFF, 16'h00FF, 16'h80FF};
      vecs[3] = '{8'h7E, 16'h1234, 16'h007E, 16'h807E};
      for (int i = 0; i < NUM_INIT; i++)
         init_tab[i] = {8'(32'h20 + i), 16'(32'h3C00 + i * 32'h0101)};

      deser_reset_n = 1'b0; init_start = 1'b0; host_req = 1'b0;
      host_addr = 8'h00; host_data = 16'h0000;
      tick(); tick();
      chk("rst_addr", ti_roic_reg_addr, 16'h0000);
      chk("rst_data", ti_roic_reg_data, 16'h0000);
      chk("rst_busy", busy, 0);
      chk("rst_ack", host_ack, 0);
      chk("rst_done", init_done, 0);
      chk("rst_idx", init_rd_idx, 0);
      chk("rst_cnt", init_cnt, 0);
      deser_reset_n = 1'b1;
      tick();

      // Table-driven single host writes
      base = mon_q.size();
      for (int i = 0; i < 4; i++) host_write_vec(vecs[i]);
      cnt = 0;
      for (int i = 0; i < 4; i++)
         if (base + i >= mon_q.size() || mon_q[base + i] != {vecs[i].addr, vecs[i].data}
             || mon_len[base + i] != HOLD) cnt++;
      chk("host_strobe_log", cnt, 0);

      // Full init burst
      base = mon_q.size();
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      chk("init_busy_start", busy, 1);
      chk("init_done_cleared", init_done, 0);
      cnt = 1;
      while (busy && cnt < 3000) begin tick(); cnt++; end
      chk("init_busy_cycles", cnt - 1, NUM_INIT * WR_CYC);
      chk("init_done", init_done, 1);
      chk("init_cnt", init_cnt, NUM_INIT);
      chk("init_strobes", mon_q.size() - base, NUM_INIT);
      chk_burst("init_order", base, NUM_INIT);

      // End marker at entry 3
      init_tab[3] = {8'hFF, 16'h0000};
      base = mon_q.size();
      init_start = 1'b1;
      tick();
      init_start = 1'b0;
      chk("end_done_cleared", init_done, 0);
      cnt = 1;
      while (busy && cnt < 3000) begin tick(); cnt++; end
      chk("end_busy_cycles", cnt - 1, 3 * WR_CYC);
      chk("end_strobes", mon_q.size() - base, 3);
      chk_burst("end_order", base, 3);
      chk("end_done", init_done, 1);
      chk("end_cnt", init_cnt, 3);
      init_tab[3] = {8'h23, 16'h3F03};

      // Asynchronous reset in the middle of a strobe
      host_addr = 8'h12; host_data = 16'hA5C3; host_req = 1'b1;
      tick();
      host_req = 1'b0;
      repeat (10) tick();
      chk("pre_rst_strobe", ti_roic_reg_addr, 16'h8012);
      #2 deser_reset_n = 1'b0;
      #1;
      chk("midrst_addr", ti_roic_reg_addr, 16'h0000);
      chk("midrst_data", ti_roic_reg_data, 16'h0000);
      chk("midrst_busy", busy, 0);
      chk("midrst_done", init_done, 0);
      chk("midrst_cnt", init_cnt, 0);
      tick(); tick();
      deser_reset_n = 1'b1;
      tick(); tick();
      chk("postrst_busy", busy, 0);
      chk("postrst_addr", ti_roic_reg_addr, 16'h0000);

      // Simultaneous init_start and host_req: burst first, then the host write
      base = mon_q.size();
      host_addr = 8'h5A; host_data = 16'hC0DE; host_req = 1'b1; init_start = 1'b1;
      first_low = 0; acks = 0; ack_at = 0;
      for (int c = 1; c <= 1300; c++) begin
         tick();
         if (c == 1) init_start = 1'b0;
         if (!busy && first_low == 0) first_low = c;
         if (host_ack) begin
            acks++;
            if (ack_at == 0) ack_at = c;
            host_req = 1'b0;
         end
      end
      chk("arb_burst_end", first_low, NUM_INIT * WR_CYC + 1);
      chk("arb_ack_cycle", ack_at, NUM_INIT * WR_CYC + 2);
      chk("arb_ack_count", acks, 1);
      chk("arb_strobes", mon_q.size() - base, NUM_INIT + 1);
      chk_burst("arb_burst_order", base, NUM_INIT);
      chk("arb_host_word", (base + NUM_INIT < mon_q.size()) ? mon_q[base + NUM_INIT] : 24'h0, 24'h5AC0DE);
      chk("arb_busy_after", busy, 0);

      // init_start during a host write is deferred; a second one during the burst is ignored
      base = mon_q.size();
      host_addr = 8'h33; host_data = 16'hBEEF; host_req = 1'b1;
      first_low = 0; rehigh = 0; burst_end = 0; late_busy = 0;
      rehigh_addr = '0; rehigh_done = 1'b1;
      for (int c = 1; c <= 1300; c++) begin
         tick();
         if (c == 1) begin
            chk("pend_host_ack", host_ack, 1);
            host_req = 1'b0;
         end
         if (c == 21)  init_start = 1'b1;
         if (c == 22)  init_start = 1'b0;
         if (c == 400) init_start = 1'b1;
         if (c == 401) init_start = 1'b0;
         if (!busy && first_low == 0) first_low = c;
         if (busy && first_low != 0 && rehigh == 0) begin
            rehigh = c; rehigh_addr = ti_roic_reg_addr; rehigh_done = init_done;
         end
         if (!busy && rehigh != 0 && burst_end == 0) burst_end = c;
         if (busy && burst_end != 0) late_busy++;
      end
      chk("pend_host_end", first_low, WR_CYC + 1);
      chk("pend_burst_start", rehigh, WR_CYC + 2);
      chk("pend_first_addr", rehigh_addr, {8'h00, init_tab[0][23:16]});
      chk("pend_done_cleared", rehigh_done, 0);
      chk("pend_burst_end", burst_end, WR_CYC + 2 + NUM_INIT * WR_CYC);
      chk("pend_no_rerun", late_busy, 0);
      chk("pend_strobes", mon_q.size() - base, NUM_INIT + 1);
      chk("pend_host_word", (base < mon_q.size()) ? mon_q[base] : 24'h0, 24'h33BEEF);
      chk_burst("pend_burst_order", base + 1, NUM_INIT);
      chk("pend_cnt", init_cnt, NUM_INIT);
      chk("pend_done", init_done, 1);

      chk("gap_violations", gap_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ti_roic_cfg_sequencer.md
# ti_roic_cfg_sequencer

Sequences register writes into the TI ROIC SPI/timing-generator configuration port, in the 5 MHz SPI clock domain. It replaces direct host driving of `ti_roic_reg_addr` and `ti_roic_reg_data` with an arbitrated scheduler that handles two sources:
- a power-up/re-init table burst;
- single host writes.

The scheduler guarantees set-up, strobe width and inter-write gap for each transfer. Its outputs connect directly to the `ti_roic_reg_addr`/`ti_roic_reg_data` inputs of the TI ROIC integration block.

## Interface
Parameters:
- `NUM_INIT`, default 16: number of init-table entries (≥ 2).
- `SPI_HOLD_CYC`, default 64: cycles DUT_EN (bit 15) is held high per write. Covers one full SPI frame plus margin.
- `SPI_GAP_CYC`, default 8: cycles DUT_EN is low between writes.

Ports:
- `clk_5mhz`  in  1  sole clock.
- `deser_reset_n`  in  1  asynchronous, active-low reset.
- `init_start`  in  1  single-cycle request to run the init table.
- `init_rd_idx`  out  clog2(NUM_INIT)  table index being read.
- `init_rd_entry`  in  24  `{addr[7:0], data[15:0]}`; driven combinationally from `init_rd_idx`, valid in the same cycle.
- `host_req`  in  1  level; host holds it until `host_ack`.
- `host_addr`  in  8  host register address.
- `host_data`  in  16  host register data.
- `host_ack`  out  1  one-cycle pulse; host write accepted and its operands captured.
- `ti_roic_reg_addr`  out  16  bit 15 = DUT_EN strobe; bits 14:8 always 0; bits 7:0 = register address.
- `ti_roic_reg_data`  out  16  register data.
- `busy`  out  1  high whenever state ≠ IDLE.
- `init_done`  out  1  level; set when the init burst completes, cleared by an accepted `init_start`.
- `init_cnt`  out  clog2(NUM_INIT)+1  number of entries written by the last burst.

## Operation
- States: IDLE, LOAD, STROBE, GAP. All outputs are registered.
- **IDLE**
  - Pending init (`init_start` this cycle or latched `init_pend`) has priority over `host_req`.
  - Init start: `init_rd_idx` ← 0, entry is captured, `init_done` ← 0, `init_cnt` ← 0, go to LOAD.
  - Otherwise, if `host_req`: capture `host_addr`/`host_data`, pulse `host_ack`, go to LOAD.
- **LOAD** (1 cycle): drive the captured address/data with bit 15 = 0, giving set-up before the DUT_EN rising edge.
- **STROBE** (`SPI_HOLD_CYC` cycles): same address/data with bit 15 = 1. Address and data stay stable throughout.
- **GAP** (`SPI_GAP_CYC` cycles): bit 15 = 0, address/data held. At the last GAP cycle:
  - Init burst: `init_cnt` increments. If `idx == NUM_INIT-1`, finish. Otherwise `init_rd_idx` increments, the entry is captured, and the state goes to LOAD.
  - Host write: go to IDLE.
- **End marker:** an init entry with `addr == 8'hFF` ends the burst at capture time. No write is issued for it; the state goes directly to IDLE with `init_done` ← 1.
- **Burst finish:** `init_done` ← 1, go to IDLE.
- **`init_start` while busy:**
  - During a host write: latched into `init_pend`, serviced next IDLE.
  - During an init burst: ignored.
- **Host requests during a burst:** not acked until the burst ends. A host write issued after an init burst is never lost.
- **Reset mid-operation:** every register returns to its reset value immediately. Any partial SPI frame is abandoned because DUT_EN drops asynchronously.

## Timing
- Reset values:
  - `ti_roic_reg_addr` = 16'h0000, `ti_roic_reg_data` = 16'h0000.
  - `host_ack`, `busy`, `init_done`, `init_pend` = 0; `init_rd_idx` = 0; `init_cnt` = 0.
  - State = IDLE.
- Cycle per write = 1 + `SPI_HOLD_CYC` + `SPI_GAP_CYC` (73 at defaults).
- Host write: `host_req` is sampled at edge n. `host_ack` is high in cycle n+1 (LOAD). Bit 15 rises at n+2. `busy` falls at n+74.
- A host request arriving in the same cycle as the IDLE return is accepted on the next edge, so IDLE lasts at least 1 cycle.
- Full init of N entries: `busy` is high for N×73 cycles.
- DUT_EN never stays high across two writes. Minimum low time between strobes is `SPI_GAP_CYC` + 1.
- Simultaneous `init_start` and `host_req` in IDLE: init wins. The host request stays pending and is acked at the first IDLE after the burst.

## Test plan
- **Reset:** assert `deser_reset_n`=0 mid-STROBE → all outputs 0 within the same cycle; after release, `busy`=0 and `ti_roic_reg_addr`=0.
- **Single host write:** `host_addr`=8'h12, `host_data`=16'hA5C3 → `host_ack` pulse 1 cycle after sampling. Then `ti_roic_reg_addr`=16'h0012 for 1 cycle, 16'h8012 for 64 cycles, 16'h0012 for 8 cycles; data is 16'hA5C3 throughout; `busy` is high for 73 cycles.
- **Full init, 16 entries:** 16 strobes in index order with correct addr/data; `init_done`=1 and `init_cnt`=16 after 1168 cycles.
- **End marker:** entry 3 has addr 8'hFF → exactly 3 strobes; `init_done`=1; `init_cnt`=3.
- **Arbitration:** `init_start` and `host_req` in the same IDLE cycle → full burst first, then the host write acked; no `host_ack` during the burst.
- **Pending init:** `init_start` pulsed during a host write → burst begins after that write's GAP plus 1 IDLE cycle; a second `init_start` during the burst has no effect.
